// File: rtl/char_plane_pkg.sv
// Shared constants, control codes and FSM state encodings for the character plane controller.
package char_plane_pkg;
    localparam int ROW_NUMBER  = 7;
    localparam int COL_NUMBER  = 20;
    localparam int ROW_BIT_LEN = 4;
    localparam int COL_BIT_LEN = 6;
    localparam int DATA_SIZE   = 8;

    localparam logic [DATA_SIZE-1:0]   BLANK_CHAR = 8'd129;
    localparam logic [ROW_BIT_LEN-1:0] LAST_ROW   = ROW_BIT_LEN'(ROW_NUMBER - 1);
    localparam logic [COL_BIT_LEN-1:0] LAST_COL   = COL_BIT_LEN'(COL_NUMBER - 1);

    localparam logic [DATA_SIZE-1:0] CHR_NEWLINE   = 8'h0A;
    localparam logic [DATA_SIZE-1:0] CHR_BACKSPACE = 8'h08;
    localparam logic [DATA_SIZE-1:0] CHR_ERASE     = 8'hFF;
    localparam logic [DATA_SIZE-1:0] CHR_FIRST_PRN = 8'h20;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WRITE     = 3'd1;
    localparam logic [2:0] ST_SCROLL_RD = 3'd2;
    localparam logic [2:0] ST_SCROLL_WR = 3'd3;
    localparam logic [2:0] ST_BLANK_ROW = 3'd4;
    localparam logic [2:0] ST_CLEAR     = 3'd5;
endpackage

// File: rtl/char_plane_ctrl_if.sv
// Character stream, status and plane port bundle between the controller and its environment.
interface char_plane_ctrl_if;
    import char_plane_pkg::*;

    logic [DATA_SIZE-1:0]   char_data;
    logic                   char_valid;
    logic                   char_ready;
    logic                   clear_req;
    logic                   busy;
    logic [ROW_BIT_LEN-1:0] cursor_row;
    logic [COL_BIT_LEN-1:0] cursor_col;
    logic                   plane_we;
    logic [ROW_BIT_LEN-1:0] plane_row_in;
    logic [COL_BIT_LEN-1:0] plane_column_in;
    logic [DATA_SIZE-1:0]   plane_data_in;
    logic                   plane_reset;
    logic                   plane_push_up;
    logic [ROW_BIT_LEN-1:0] plane_row_out;
    logic [COL_BIT_LEN-1:0] plane_column_out;
    logic [DATA_SIZE-1:0]   plane_data_out;

    // Controller side
    modport master (
        input  char_data, char_valid, clear_req, plane_data_out,
        output char_ready, busy, cursor_row, cursor_col,
               plane_we, plane_row_in, plane_column_in, plane_data_in,
               plane_reset, plane_push_up, plane_row_out, plane_column_out
    );

    // Source / plane side
    modport slave (
        output char_data, char_valid, clear_req, plane_data_out,
        input  char_ready, busy, cursor_row, cursor_col,
               plane_we, plane_row_in, plane_column_in, plane_data_in,
               plane_reset, plane_push_up, plane_row_out, plane_column_out
    );
endinterface

// File: rtl/plane_cell_walker.sv
// Row-major cell iterator shared by scroll copy, bottom-row blanking and full clear.
module plane_cell_walker
    import char_plane_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [ROW_BIT_LEN-1:0] i_row_start,
    input  logic [ROW_BIT_LEN-1:0] i_row_end,
    input  logic                   i_step,
    output logic [ROW_BIT_LEN-1:0] o_row,
    output logic [COL_BIT_LEN-1:0] o_col,
    output logic [ROW_BIT_LEN-1:0] o_next_row,
    output logic [COL_BIT_LEN-1:0] o_next_col,
    output logic                   o_done
);
    logic [ROW_BIT_LEN-1:0] r_row;
    logic [ROW_BIT_LEN-1:0] r_row_end;
    logic [COL_BIT_LEN-1:0] r_col;
    logic [ROW_BIT_LEN-1:0] w_next_row;
    logic [COL_BIT_LEN-1:0] w_next_col;

    // Cell that follows the current one, wrapping to the next row after the last column
    always_comb begin
        w_next_row = r_row;
        w_next_col = r_col + 6'd1;
        if (r_col == LAST_COL) begin
            w_next_row = r_row + 4'd1;
            w_next_col = 6'd0;
        end else begin
            w_next_col = r_col + 6'd1;
        end
    end

    // Load the start cell or advance one cell per step
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row     <= 4'd0;
            r_col     <= 6'd0;
            r_row_end <= 4'd0;
        end else if (i_start) begin
            r_row     <= i_row_start;
            r_col     <= 6'd0;
            r_row_end <= i_row_end;
        end else if (i_step) begin
            r_row <= w_next_row;
            r_col <= w_next_col;
        end else begin
            r_row <= r_row;
        end
    end

    assign o_row      = r_row;
    assign o_col      = r_col;
    assign o_next_row = w_next_row;
    assign o_next_col = w_next_col;
    assign o_done     = (r_row == r_row_end) && (r_col == LAST_COL);
endmodule

// File: rtl/char_plane_ctrl.sv
// Character plane sequencer: cursor handling, line wrap, backspace, clear and copy-based scroll.
module char_plane_ctrl
    import char_plane_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    char_plane_ctrl_if.master plane_bus
);
    logic [2:0]             r_state;
    logic                   r_clear_pend;
    logic [ROW_BIT_LEN-1:0] r_cur_row, r_nxt_row, r_row_in;
    logic [COL_BIT_LEN-1:0] r_cur_col, r_nxt_col, r_col_in;
    logic                   r_ovf, r_we;
    logic [DATA_SIZE-1:0]   r_data_in;

    logic                   w_char_ready, w_accept, w_clear_go;
    logic                   w_dec_we, w_dec_ovf;
    logic [ROW_BIT_LEN-1:0] w_dec_row, w_dec_nrow;
    logic [COL_BIT_LEN-1:0] w_dec_col, w_dec_ncol;
    logic [DATA_SIZE-1:0]   w_dec_data;
    logic                   w_walk_start, w_walk_step, w_walk_done;
    logic [ROW_BIT_LEN-1:0] w_walk_row_start, w_walk_row, w_walk_next_row;
    logic [COL_BIT_LEN-1:0] w_walk_col, w_walk_next_col;

    assign w_char_ready = (r_state == ST_IDLE) && !r_clear_pend && !plane_bus.clear_req;
    assign w_accept     = plane_bus.char_valid && w_char_ready;
    assign w_clear_go   = (r_state == ST_IDLE) && (r_clear_pend || plane_bus.clear_req);

    plane_cell_walker u_walker (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (w_walk_start),
        .i_row_start (w_walk_row_start),
        .i_row_end   (LAST_ROW),
        .i_step      (w_walk_step),
        .o_row       (w_walk_row),
        .o_col       (w_walk_col),
        .o_next_row  (w_walk_next_row),
        .o_next_col  (w_walk_next_col),
        .o_done      (w_walk_done)
    );

    // Decode the offered character into a write (if any) and the cursor position that follows it
    always_comb begin
        w_dec_we   = 1'b0;
        w_dec_ovf  = 1'b0;
        w_dec_row  = r_cur_row;
        w_dec_col  = r_cur_col;
        w_dec_data = plane_bus.char_data;
        w_dec_nrow = r_cur_row;
        w_dec_ncol = r_cur_col;
        if (plane_bus.char_data == CHR_NEWLINE) begin
            w_dec_ncol = 6'd0;
            if (r_cur_row == LAST_ROW) w_dec_ovf  = 1'b1;
            else                       w_dec_nrow = r_cur_row + 4'd1;
        end else if (plane_bus.char_data == CHR_BACKSPACE) begin
            if (r_cur_col != 6'd0) begin
                w_dec_we   = 1'b1;
                w_dec_col  = r_cur_col - 6'd1;
                w_dec_ncol = r_cur_col - 6'd1;
                w_dec_data = BLANK_CHAR;
            end else if (r_cur_row != 4'd0) begin
                w_dec_we   = 1'b1;
                w_dec_row  = r_cur_row - 4'd1;
                w_dec_col  = LAST_COL;
                w_dec_nrow = r_cur_row - 4'd1;
                w_dec_ncol = LAST_COL;
                w_dec_data = BLANK_CHAR;
            end else begin
                w_dec_we = 1'b0;
            end
        end else if (plane_bus.char_data >= CHR_FIRST_PRN) begin
            w_dec_we = 1'b1;
            if (plane_bus.char_data == CHR_ERASE) w_dec_data = BLANK_CHAR;
            else                                  w_dec_data = plane_bus.char_data;
            if (r_cur_col == LAST_COL) begin
                w_dec_ncol = 6'd0;
                if (r_cur_row == LAST_ROW) w_dec_ovf  = 1'b1;
                else                       w_dec_nrow = r_cur_row + 4'd1;
            end else begin
                w_dec_ncol = r_cur_col + 6'd1;
            end
        end else begin
            w_dec_we = 1'b0;
        end
    end

    // Walker control: scroll reads rows 1..last, bottom-row blank and clear walk to the last row
    always_comb begin
        w_walk_start     = 1'b0;
        w_walk_step      = 1'b0;
        w_walk_row_start = 4'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_clear_go) w_walk_start = 1'b1;
                else            w_walk_start = 1'b0;
            end
            ST_WRITE: begin
                if (r_ovf) begin
                    w_walk_start     = 1'b1;
                    w_walk_row_start = 4'd1;
                end else begin
                    w_walk_start = 1'b0;
                end
            end
            ST_SCROLL_WR: begin
                if (w_walk_done) begin
                    w_walk_start     = 1'b1;
                    w_walk_row_start = LAST_ROW;
                end else begin
                    w_walk_step = 1'b1;
                end
            end
            ST_BLANK_ROW, ST_CLEAR: begin
                if (!w_walk_done) w_walk_step = 1'b1;
                else              w_walk_step = 1'b0;
            end
            default: w_walk_start = 1'b0;
        endcase
    end

    // Main sequencer: state, cursor, deferred clear and the registered plane write port
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_clear_pend <= 1'b0;
            r_cur_row    <= 4'd0;
            r_cur_col    <= 6'd0;
            r_nxt_row    <= 4'd0;
            r_nxt_col    <= 6'd0;
            r_ovf        <= 1'b0;
            r_we         <= 1'b0;
            r_row_in     <= 4'd0;
            r_col_in     <= 6'd0;
            r_data_in    <= BLANK_CHAR;
        end else begin
            if ((r_state != ST_IDLE) && plane_bus.clear_req) r_clear_pend <= 1'b1;
            else if (r_state == ST_IDLE)                     r_clear_pend <= 1'b0;
            else                                             r_clear_pend <= r_clear_pend;

            case (r_state)
                ST_IDLE: begin
                    if (w_clear_go) begin
                        r_state   <= ST_CLEAR;
                        r_we      <= 1'b1;
                        r_row_in  <= 4'd0;
                        r_col_in  <= 6'd0;
                        r_data_in <= BLANK_CHAR;
                    end else if (w_accept) begin
                        r_state   <= ST_WRITE;
                        r_we      <= w_dec_we;
                        r_row_in  <= w_dec_row;
                        r_col_in  <= w_dec_col;
                        r_data_in <= w_dec_data;
                        r_nxt_row <= w_dec_nrow;
                        r_nxt_col <= w_dec_ncol;
                        r_ovf     <= w_dec_ovf;
                    end else begin
                        r_we <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    r_we <= 1'b0;
                    if (r_ovf) begin
                        r_cur_row <= LAST_ROW;
                        r_cur_col <= 6'd0;
                        r_state   <= ST_SCROLL_RD;
                    end else begin
                        r_cur_row <= r_nxt_row;
                        r_cur_col <= r_nxt_col;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_SCROLL_RD: begin
                    r_we      <= 1'b1;
                    r_row_in  <= w_walk_row - 4'd1;
                    r_col_in  <= w_walk_col;
                    r_data_in <= plane_bus.plane_data_out;
                    r_state   <= ST_SCROLL_WR;
                end
                ST_SCROLL_WR: begin
                    if (w_walk_done) begin
                        r_we      <= 1'b1;
                        r_row_in  <= LAST_ROW;
                        r_col_in  <= 6'd0;
                        r_data_in <= BLANK_CHAR;
                        r_state   <= ST_BLANK_ROW;
                    end else begin
                        r_we    <= 1'b0;
                        r_state <= ST_SCROLL_RD;
                    end
                end
                ST_BLANK_ROW, ST_CLEAR: begin
                    if (w_walk_done) begin
                        r_we    <= 1'b0;
                        r_state <= ST_IDLE;
                        if (r_state == ST_CLEAR) begin
                            r_cur_row <= 4'd0;
                            r_cur_col <= 6'd0;
                        end else begin
                            r_cur_row <= r_cur_row;
                        end
                    end else begin
                        r_we     <= 1'b1;
                        r_row_in <= w_walk_next_row;
                        r_col_in <= w_walk_next_col;
                    end
                end
                default: begin
                    r_we    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign plane_bus.char_ready       = w_char_ready;
    assign plane_bus.busy             = (r_state == ST_SCROLL_RD) || (r_state == ST_SCROLL_WR) ||
                                        (r_state == ST_BLANK_ROW) || (r_state == ST_CLEAR);
    assign plane_bus.cursor_row       = r_cur_row;
    assign plane_bus.cursor_col       = r_cur_col;
    assign plane_bus.plane_we         = r_we;
    assign plane_bus.plane_row_in     = r_row_in;
    assign plane_bus.plane_column_in  = r_col_in;
    assign plane_bus.plane_data_in    = r_data_in;
    assign plane_bus.plane_reset      = 1'b0;
    assign plane_bus.plane_push_up    = 1'b0;
    assign plane_bus.plane_row_out    = w_walk_row;
    assign plane_bus.plane_column_out = w_walk_col;
endmodule

// File: tb/tb_char_plane_ctrl.sv
// Testbench for char_plane_ctrl: behavioural plane, screen-level reference model, directed + random steps.
module tb_char_plane_ctrl;
    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;

    char_plane_ctrl_if bus ();

    char_plane_ctrl dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .plane_bus (bus)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural plane: captures on the falling edge, combinational read port
    logic [7:0] plane_mem [7][20];
    int         we_cnt   = 0;
    int         busy_cyc = 0;
    logic [3:0] last_row;
    logic [5:0] last_col;
    logic [7:0] last_data;

    assign bus.plane_data_out = (bus.plane_row_out < 4'd7 && bus.plane_column_out < 6'd20) ?
                                plane_mem[bus.plane_row_out][bus.plane_column_out] : 8'h00;

    always @(negedge i_clk) begin
        if (bus.plane_we === 1'b1) begin
            if (bus.plane_row_in < 4'd7 && bus.plane_column_in < 6'd20)
                plane_mem[bus.plane_row_in][bus.plane_column_in] <= bus.plane_data_in;
            we_cnt    <= we_cnt + 1;
            last_row  <= bus.plane_row_in;
            last_col  <= bus.plane_column_in;
            last_data <= bus.plane_data_in;
        end
        if (bus.busy === 1'b1) busy_cyc <= busy_cyc + 1;
    end

    // Reference screen model
    logic [7:0] exp_mem [7][20];
    int cur_r = 0;
    int cur_c = 0;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 20; c++) exp_mem[r][c] = 8'd129;
        cur_r = 0;
        cur_c = 0;
    endtask

    task automatic model_down();
        if (cur_r == 6) begin
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 20; c++) exp_mem[r][c] = exp_mem[r+1][c];
            for (int c = 0; c < 20; c++) exp_mem[6][c] = 8'd129;
        end else begin
            cur_r++;
        end
    endtask

    task automatic model_char(input logic [7:0] ch);
        if (ch == 8'h0A) begin
            cur_c = 0;
            model_down();
        end else if (ch == 8'h08) begin
            if (cur_c > 0) begin
                cur_c--;
                exp_mem[cur_r][cur_c] = 8'd129;
            end else if (cur_r > 0) begin
                cur_r--;
                cur_c = 19;
                exp_mem[cur_r][cur_c] = 8'd129;
            end
        end else if (ch >= 8'h20) begin
            exp_mem[cur_r][cur_c] = (ch == 8'hFF) ? 8'd129 : ch;
            cur_c++;
            if (cur_c == 20) begin
                cur_c = 0;
                model_down();
            end
        end
    endtask

    task automatic send_char(input logic [7:0] ch);
        int n = 0;
        bus.char_data  = ch;
        bus.char_valid = 1'b1;
        while (bus.char_ready !== 1'b1 && n < 2000) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("ready_wait", 32'(n < 2000), 32'd1);
        @(posedge i_clk); #1;
        bus.char_valid = 1'b0;
        model_char(ch);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((bus.char_ready !== 1'b1 || bus.busy !== 1'b0) && n < 5000) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk(tag, 32'(n < 5000), 32'd1);
    endtask

    task automatic pulse_clear();
        bus.clear_req = 1'b1;
        @(posedge i_clk); #1;
        bus.clear_req = 1'b0;
    endtask

    task automatic chk_plane(input string tag);
        int mism = 0;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 20; c++)
                if (plane_mem[r][c] !== exp_mem[r][c]) mism++;
        chk({tag, "_cells_wrong"}, 32'(mism), 32'd0);
        chk({tag, "_cur_row"}, 32'(bus.cursor_row), 32'(cur_r));
        chk({tag, "_cur_col"}, 32'(bus.cursor_col), 32'(cur_c));
    endtask

    function automatic logic [7:0] rnd_print();
        return 8'($urandom_range(254, 32));
    endfunction

    initial begin
        int b0, w0, n, row6_blank, sel;
        logic [7:0] ch;
        bus.char_data  = 8'h00;
        bus.char_valid = 1'b0;
        bus.clear_req  = 1'b0;

        // Reset values, applied before any clock edge
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_we", 32'(bus.plane_we), 32'd0);
        chk("rst_cur_row", 32'(bus.cursor_row), 32'd0);
        chk("rst_cur_col", 32'(bus.cursor_col), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_data_in", 32'(bus.plane_data_in), 32'd129);
        chk("rst_addr_in", 32'({bus.plane_row_in, bus.plane_column_in}), 32'd0);
        chk("rst_addr_out", 32'({bus.plane_row_out, bus.plane_column_out}), 32'd0);
        chk("rst_tied", 32'({bus.plane_reset, bus.plane_push_up}), 32'd0);
        chk("rst_ready", 32'(bus.char_ready), 32'd1);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Single printable: write during the cycle after accept, cursor moves on the next edge
        w0 = we_cnt;
        chk("t1_ready", 32'(bus.char_ready), 32'd1);
        bus.char_data  = 8'h41;
        bus.char_valid = 1'b1;
        @(posedge i_clk); #1;
        bus.char_valid = 1'b0;
        model_char(8'h41);
        chk("t1_we_on", 32'(bus.plane_we), 32'd1);
        chk("t1_addr", 32'({bus.plane_row_in, bus.plane_column_in}), 32'd0);
        chk("t1_data", 32'(bus.plane_data_in), 32'h41);
        chk("t1_cur_col_hold", 32'(bus.cursor_col), 32'd0);
        @(posedge i_clk); #1;
        chk("t1_we_off", 32'(bus.plane_we), 32'd0);
        chk("t1_cur_row", 32'(bus.cursor_row), 32'd0);
        chk("t1_cur_col", 32'(bus.cursor_col), 32'd1);
        chk("t1_we_count", 32'(we_cnt - w0), 32'd1);

        // Full clear: 140 busy cycles, 140 writes of the blank id
        b0 = busy_cyc;
        w0 = we_cnt;
        pulse_clear();
        model_clear();
        wait_idle("clr_idle");
        chk("clr_busy", 32'(busy_cyc - b0), 32'd140);
        chk("clr_writes", 32'(we_cnt - w0), 32'd140);
        chk_plane("clr");

        // One full row of printables: wrap to row 1, no scroll
        b0 = busy_cyc;
        for (int i = 0; i < 20; i++) send_char(rnd_print());
        wait_idle("row_idle");
        chk("row_busy", 32'(busy_cyc - b0), 32'd0);
        chk_plane("row0");

        // Fill rows 1..5 and most of row 6, then newline from the last row scrolls
        for (int i = 0; i < 119; i++) send_char(rnd_print());
        wait_idle("fill_idle");
        chk_plane("fill");
        b0 = busy_cyc;
        send_char(8'h0A);
        wait_idle("scr_idle");
        chk("scr_busy", 32'(busy_cyc - b0), 32'd260);
        chk_plane("scr");
        row6_blank = 0;
        for (int c = 0; c < 20; c++) if (plane_mem[6][c] === 8'd129) row6_blank++;
        chk("scr_row6_blank", 32'(row6_blank), 32'd20);

        // Backspace from column 0 of row 2, then at the home position
        pulse_clear();
        model_clear();
        wait_idle("bs_clr");
        send_char(8'h0A);
        send_char(8'h0A);
        wait_idle("bs_nl");
        w0 = we_cnt;
        send_char(8'h08);
        wait_idle("bs1_idle");
        chk("bs1_writes", 32'(we_cnt - w0), 32'd1);
        chk("bs1_addr", 32'({last_row, last_col}), 32'({4'd1, 6'd19}));
        chk("bs1_data", 32'(last_data), 32'd129);
        chk_plane("bs1");
        pulse_clear();
        model_clear();
        wait_idle("bs2_clr");
        w0 = we_cnt;
        send_char(8'h08);
        wait_idle("bs2_idle");
        chk("bs2_writes", 32'(we_cnt - w0), 32'd0);
        chk_plane("bs2");

        // clear_req and char_valid together in IDLE: clear wins, character follows
        send_char(8'h33);
        send_char(8'h34);
        wait_idle("cv_pre");
        b0 = busy_cyc;
        w0 = we_cnt;
        bus.clear_req  = 1'b1;
        bus.char_data  = 8'h5A;
        bus.char_valid = 1'b1;
        #1;
        chk("cv_ready_low", 32'(bus.char_ready), 32'd0);
        @(posedge i_clk); #1;
        bus.clear_req = 1'b0;
        chk("cv_busy", 32'(bus.busy), 32'd1);
        model_clear();
        send_char(8'h5A);
        wait_idle("cv_idle");
        chk("cv_busy_cyc", 32'(busy_cyc - b0), 32'd140);
        chk("cv_writes", 32'(we_cnt - w0), 32'd141);
        chk("cv_last", 32'({last_row, last_col, last_data}), 32'({4'd0, 6'd0, 8'h5A}));
        chk_plane("cv");

        // clear_req during a scroll is deferred until the scroll completes
        for (int i = 0; i < 6; i++) send_char(8'h0A);
        wait_idle("sc_pre");
        b0 = busy_cyc;
        send_char(8'h0A);
        repeat (10) @(posedge i_clk);
        #1;
        chk("sc_busy_mid", 32'(bus.busy), 32'd1);
        pulse_clear();
        model_clear();
        wait_idle("sc_idle");
        chk("sc_busy_cyc", 32'(busy_cyc - b0), 32'd400);
        chk_plane("sc");

        // Randomized character mix against the screen model
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(99, 0));
            if (sel < 60)      ch = rnd_print();
            else if (sel < 70) ch = 8'h0A;
            else if (sel < 85) ch = 8'h08;
            else if (sel < 90) ch = 8'hFF;
            else               ch = 8'($urandom_range(31, 0));
            send_char(ch);
            if (i % 50 == 49) begin
                wait_idle("rnd_idle");
                chk_plane("rnd");
            end
        end

        // Asynchronous reset part-way through a scroll
        pulse_clear();
        model_clear();
        wait_idle("ra_clr");
        for (int i = 0; i < 6; i++) send_char(8'h0A);
        wait_idle("ra_pre");
        send_char(8'h0A);
        n = 0;
        while (bus.busy !== 1'b1 && n < 10) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("ra_busy_start", 32'(bus.busy), 32'd1);
        repeat (99) @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("ra_we", 32'(bus.plane_we), 32'd0);
        chk("ra_cursor", 32'({bus.cursor_row, bus.cursor_col}), 32'd0);
        chk("ra_busy", 32'(bus.busy), 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        chk("ra_ready", 32'(bus.char_ready), 32'd1);
        b0 = busy_cyc;
        pulse_clear();
        model_clear();
        wait_idle("ra_clr2");
        chk("ra_clr_busy", 32'(busy_cyc - b0), 32'd140);
        chk_plane("ra");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
